// File: rtl/pattern_gen_if.sv
// Video-side bundle for pattern_gen: timing inputs from the sync generator
// and the registered pixel/sync outputs going to the RGB pins.
interface pattern_gen_if #(
  parameter int CORDW = 10,
  parameter int R_W   = 5,
  parameter int G_W   = 6,
  parameter int B_W   = 5
);
  logic [2:0]       MODE;
  logic [CORDW-1:0] SX;
  logic [CORDW-1:0] SY;
  logic             DE_I;
  logic             HSYNC_I;
  logic             VSYNC_I;
  logic             DE;
  logic             HSYNC;
  logic             VSYNC;
  logic [R_W-1:0]   RED;
  logic [G_W-1:0]   GREEN;
  logic [B_W-1:0]   BLUE;
  logic             FRAME;

  // The pattern generator itself: consumes timing, produces pixels.
  modport master (
    input  MODE, SX, SY, DE_I, HSYNC_I, VSYNC_I,
    output DE, HSYNC, VSYNC, RED, GREEN, BLUE, FRAME
  );

  // The surrounding system: supplies timing, receives pixels.
  modport slave (
    output MODE, SX, SY, DE_I, HSYNC_I, VSYNC_I,
    input  DE, HSYNC, VSYNC, RED, GREEN, BLUE, FRAME
  );
endinterface

// File: rtl/pattern_gen.sv
// Selectable test-pattern generator (colour square, bars, checkerboard,
// bouncing box). Every output is registered one PCLK after its timing input,
// and the active pattern only changes at the first pixel of vertical blanking.
module pattern_gen #(
  parameter int CORDW     = 10,
  parameter int H_RES     = 640,
  parameter int V_RES     = 480,
  parameter int R_W       = 5,
  parameter int G_W       = 6,
  parameter int B_W       = 5,
  parameter int CHK_LOG2  = 5,
  parameter int BOX       = 32,
  parameter int STEP      = 4,
  parameter bit SYNC_IDLE = 1'b1
) (
  input  logic          PCLK,
  input  logic          RESET_n,
  pattern_gen_if.master vid
);

  localparam logic [2:0] MODE_SQUARE = 3'd0;
  localparam logic [2:0] MODE_BARS   = 3'd1;
  localparam logic [2:0] MODE_CHECK  = 3'd2;
  localparam logic [2:0] MODE_BOX    = 3'd3;

  localparam int               BAR_W    = H_RES / 8;
  localparam logic [B_W-1:0]   BLUE_MSB = B_W'(1) << (B_W - 1);
  localparam logic [CORDW:0]   BOX_W    = (CORDW + 1)'(BOX);

  logic [2:0]       mode_reg;
  logic             frame_strobe;
  logic [CORDW-1:0] bx;
  logic [CORDW-1:0] by;

  // First pixel of vertical blanking: the only point where mode and box move.
  assign frame_strobe = (vid.SX == '0) && (vid.SY == CORDW'(V_RES));

  // Box position/direction, one identical reflecting walker per axis
  // (gi = 0 is x against H_RES, gi = 1 is y against V_RES).
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_axis
      localparam int               LIM    = (gi == 0) ? H_RES : V_RES;
      localparam logic [CORDW+1:0] SPAN   = (CORDW + 2)'(BOX + STEP);
      localparam logic [CORDW+1:0] LIM_X  = (CORDW + 2)'(LIM);
      localparam logic [CORDW-1:0] STEP_C = CORDW'(STEP);

      logic [CORDW-1:0] pos_reg;
      logic             neg_reg;

      // Step the box once per frame, reversing before it would leave the screen
      always_ff @(posedge PCLK) begin
        if (!RESET_n) begin
          pos_reg <= '0;
          neg_reg <= 1'b0;
        end else if (frame_strobe) begin
          if (!neg_reg) begin
            if ({2'b00, pos_reg} + SPAN > LIM_X) begin
              neg_reg <= 1'b1;
              pos_reg <= pos_reg - STEP_C;
            end else begin
              pos_reg <= pos_reg + STEP_C;
            end
          end else if (pos_reg < STEP_C) begin
            neg_reg <= 1'b0;
            pos_reg <= pos_reg + STEP_C;
          end else begin
            pos_reg <= pos_reg - STEP_C;
          end
        end
      end
    end
  endgenerate

  assign bx = g_axis[0].pos_reg;
  assign by = g_axis[1].pos_reg;

  // Colour square: native 5/6/5 values, MSB-aligned onto the channel widths
  // (wider channels get zero LSBs, narrower ones lose their LSBs).
  logic [4:0]     sq_r5;
  logic [5:0]     sq_g6;
  logic [4:0]     sq_b5;
  logic [R_W-1:0] sq_r;
  logic [G_W-1:0] sq_g;
  logic [B_W-1:0] sq_b;
  logic           in_square;

  assign sq_r5     = {vid.SY[7:6], vid.SX[7:5]};
  assign sq_g6     = vid.SY[5:0];
  assign sq_b5     = vid.SX[4:0];
  assign in_square = ((vid.SX >> 8) == '0) && ((vid.SY >> 8) == '0);

  generate
    if (R_W >= 5) begin : g_r_pad
      assign sq_r = R_W'(sq_r5) << (R_W - 5);
    end else begin : g_r_trim
      assign sq_r = R_W'(sq_r5 >> (5 - R_W));
    end
    if (G_W >= 6) begin : g_g_pad
      assign sq_g = G_W'(sq_g6) << (G_W - 6);
    end else begin : g_g_trim
      assign sq_g = G_W'(sq_g6 >> (6 - G_W));
    end
    if (B_W >= 5) begin : g_b_pad
      assign sq_b = B_W'(sq_b5) << (B_W - 5);
    end else begin : g_b_trim
      assign sq_b = B_W'(sq_b5 >> (5 - B_W));
    end
  endgenerate

  // Vertical bars: index clamps at 7 so any remainder columns stay black.
  logic [CORDW-1:0] bar_q;
  logic [2:0]       bar_idx;

  assign bar_q   = vid.SX / CORDW'(BAR_W);
  assign bar_idx = (bar_q > CORDW'(7)) ? 3'd7 : bar_q[2:0];

  // Checkerboard and bouncing-box hit tests.
  logic chk_on;
  logic in_box;

  assign chk_on = vid.SX[CHK_LOG2] ^ vid.SY[CHK_LOG2];
  assign in_box = ({1'b0, vid.SX} >= {1'b0, bx}) &&
                  ({1'b0, vid.SX} <  {1'b0, bx} + BOX_W) &&
                  ({1'b0, vid.SY} >= {1'b0, by}) &&
                  ({1'b0, vid.SY} <  {1'b0, by} + BOX_W);

  logic [R_W-1:0] red_next;
  logic [G_W-1:0] green_next;
  logic [B_W-1:0] blue_next;

  // Pick the pixel colour for the active pattern; blanking always gives black
  always_comb begin
    red_next   = '0;
    green_next = '0;
    blue_next  = '0;
    if (vid.DE_I) begin
      case (mode_reg)
        MODE_SQUARE: begin
          if (in_square) begin
            red_next   = sq_r;
            green_next = sq_g;
            blue_next  = sq_b;
          end
        end
        MODE_BARS: begin
          // white, yellow, cyan, green, magenta, red, blue, black
          red_next   = {R_W{~bar_idx[1]}};
          green_next = {G_W{~bar_idx[2]}};
          blue_next  = {B_W{~bar_idx[0]}};
        end
        MODE_CHECK: begin
          if (chk_on) begin
            red_next   = '1;
            green_next = '1;
            blue_next  = '1;
          end
        end
        MODE_BOX: begin
          if (in_box) begin
            red_next   = '1;
            green_next = '1;
            blue_next  = '1;
          end else begin
            blue_next  = BLUE_MSB;
          end
        end
        default: begin
          // reserved modes stay black
        end
      endcase
    end
  end

  // Register pixels, delayed timing, frame pulse and the frame-latched mode
  always_ff @(posedge PCLK) begin
    if (!RESET_n) begin
      mode_reg  <= MODE_SQUARE;
      vid.RED   <= '0;
      vid.GREEN <= '0;
      vid.BLUE  <= '0;
      vid.DE    <= 1'b0;
      vid.HSYNC <= SYNC_IDLE;
      vid.VSYNC <= SYNC_IDLE;
      vid.FRAME <= 1'b0;
    end else begin
      vid.RED   <= red_next;
      vid.GREEN <= green_next;
      vid.BLUE  <= blue_next;
      vid.DE    <= vid.DE_I;
      vid.HSYNC <= vid.HSYNC_I;
      vid.VSYNC <= vid.VSYNC_I;
      vid.FRAME <= frame_strobe;
      if (frame_strobe) begin
        mode_reg <= vid.MODE;
      end
    end
  end

endmodule

// File: tb/tb_pattern_gen.sv
// Directed bench for pattern_gen: a 5/6/5 instance plus an 8/8/8 instance
// driven by the same timing, with a small box-position model for mode 3.
module tb_pattern_gen;

  localparam int H_RES = 640;
  localparam int V_RES = 480;
  localparam int BOX   = 32;
  localparam int STEP  = 4;

  logic       PCLK = 1'b0;
  logic       RESET_n;
  logic [2:0] mode;
  logic [9:0] sx;
  logic [9:0] sy;
  logic       de_i;
  logic       hs_i;
  logic       vs_i;

  int tests       = 0;
  int fails       = 0;
  int strobes     = 0;
  int frame_seen  = 0;
  int frame_extra = 0;
  int mbx         = 0;
  int mby         = 0;
  bit mdxn        = 1'b0;
  bit mdyn        = 1'b0;

  always #5 PCLK = ~PCLK;

  pattern_gen_if #(.CORDW(10), .R_W(5), .G_W(6), .B_W(5)) vid ();
  pattern_gen_if #(.CORDW(10), .R_W(8), .G_W(8), .B_W(8)) vid8 ();

  assign vid.MODE     = mode;
  assign vid.SX       = sx;
  assign vid.SY       = sy;
  assign vid.DE_I     = de_i;
  assign vid.HSYNC_I  = hs_i;
  assign vid.VSYNC_I  = vs_i;
  assign vid8.MODE    = mode;
  assign vid8.SX      = sx;
  assign vid8.SY      = sy;
  assign vid8.DE_I    = de_i;
  assign vid8.HSYNC_I = hs_i;
  assign vid8.VSYNC_I = vs_i;

  pattern_gen #(
    .CORDW(10), .H_RES(H_RES), .V_RES(V_RES), .R_W(5), .G_W(6), .B_W(5),
    .CHK_LOG2(5), .BOX(BOX), .STEP(STEP), .SYNC_IDLE(1'b1)
  ) dut (
    .PCLK(PCLK), .RESET_n(RESET_n), .vid(vid)
  );

  pattern_gen #(
    .CORDW(10), .H_RES(H_RES), .V_RES(V_RES), .R_W(8), .G_W(8), .B_W(8),
    .CHK_LOG2(5), .BOX(BOX), .STEP(STEP), .SYNC_IDLE(1'b1)
  ) dut8 (
    .PCLK(PCLK), .RESET_n(RESET_n), .vid(vid8)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
    end else begin
      $display("[TB] %s got=%0d exp=%0d ok", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the edge; outputs are read at the same point.
  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  // Expected box motion along one axis for one frame strobe.
  task automatic axis_step(inout int p, inout bit neg, input int lim);
    if (!neg) begin
      if (p + BOX + STEP > lim) begin
        neg = 1'b1;
        p   = p - STEP;
      end else begin
        p = p + STEP;
      end
    end else if (p < STEP) begin
      neg = 1'b0;
      p   = p + STEP;
    end else begin
      p = p - STEP;
    end
  endtask

  task automatic do_strobe();
    sx   = 10'd0;
    sy   = 10'(V_RES);
    de_i = 1'b0;
    tick();
    if (vid.FRAME === 1'b1) frame_seen++;
    axis_step(mbx, mdxn, H_RES);
    axis_step(mby, mdyn, V_RES);
    strobes++;
    sx = 10'd1;
    tick();
    if (vid.FRAME !== 1'b0) frame_extra++;
  endtask

  task automatic probe(input string tag, input int x, input int y,
                       input int er, input int eg, input int eb);
    sx   = 10'(x);
    sy   = 10'(y);
    de_i = 1'b1;
    tick();
    check({tag, ".r"}, 32'(vid.RED),   32'(er));
    check({tag, ".g"}, 32'(vid.GREEN), 32'(eg));
    check({tag, ".b"}, 32'(vid.BLUE),  32'(eb));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with active timing inputs applied
    RESET_n = 1'b0;
    mode    = 3'd0;
    sx      = 10'd100;
    sy      = 10'd70;
    de_i    = 1'b1;
    hs_i    = 1'b0;
    vs_i    = 1'b0;
    repeat (3) tick();
    check("rst.red",   32'(vid.RED),   0);
    check("rst.green", 32'(vid.GREEN), 0);
    check("rst.blue",  32'(vid.BLUE),  0);
    check("rst.de",    32'(vid.DE),    0);
    check("rst.hsync", 32'(vid.HSYNC), 1);
    check("rst.vsync", 32'(vid.VSYNC), 1);
    check("rst.frame", 32'(vid.FRAME), 0);

    // Mode 0 after release, one-cycle latency
    RESET_n = 1'b1;
    hs_i    = 1'b1;
    vs_i    = 1'b1;
    tick();
    check("sq.red",   32'(vid.RED),   11);
    check("sq.green", 32'(vid.GREEN), 6);
    check("sq.blue",  32'(vid.BLUE),  4);
    check("sq.de",    32'(vid.DE),    1);
    check("sq8.red",   32'(vid8.RED),   88);
    check("sq8.green", 32'(vid8.GREEN), 24);
    check("sq8.blue",  32'(vid8.BLUE),  32);

    // Blanking forces black; sync follows its input
    de_i = 1'b0;
    hs_i = 1'b0;
    tick();
    check("blank.red",   32'(vid.RED),   0);
    check("blank.green", 32'(vid.GREEN), 0);
    check("blank.blue",  32'(vid.BLUE),  0);
    check("blank.de",    32'(vid.DE),    0);
    check("blank.hsync", 32'(vid.HSYNC), 0);
    hs_i = 1'b1;

    // MODE=2 requested mid-frame: still mode 0 until the strobe
    mode = 3'd2;
    probe("defer", 32, 100, 9, 36, 0);
    do_strobe();
    probe("chk.white", 32, 0, 31, 63, 31);
    probe("chk.black", 32, 32, 0, 0, 0);

    // Vertical bars
    mode = 3'd1;
    do_strobe();
    probe("bar.yellow", 85, 10, 31, 63, 0);
    check("bar8.red",   32'(vid8.RED),   255);
    check("bar8.green", 32'(vid8.GREEN), 255);
    check("bar8.blue",  32'(vid8.BLUE),  0);
    probe("bar.cyan",  160, 10, 0, 63, 31);
    probe("bar.red",   400, 10, 31, 0, 0);
    probe("bar.black", 639, 10, 0, 0, 0);

    // Bouncing box: bottom edge
    mode = 3'd3;
    do_strobe();
    while (strobes < 112) do_strobe();
    probe("y112.in",  mbx, 448, 31, 63, 31);
    probe("y112.out", mbx, 447, 0, 0, 16);
    do_strobe();
    probe("y113.in",  mbx, 444, 31, 63, 31);
    probe("y113.out", mbx, 443, 0, 0, 16);
    probe("y113.end", mbx, 475, 31, 63, 31);
    probe("y113.bot", mbx, 476, 0, 0, 16);

    // Bouncing box: right edge
    while (strobes < 152) do_strobe();
    probe("x152.in",  608, mby, 31, 63, 31);
    probe("x152.out", 607, mby, 0, 0, 16);
    check("x152.blue8", 32'(vid8.BLUE), 128);
    do_strobe();
    probe("x153.in",   604, mby, 31, 63, 31);
    probe("x153.out",  603, mby, 0, 0, 16);
    probe("x153.end",  635, mby, 31, 63, 31);
    probe("x153.rgt",  636, mby, 0, 0, 16);

    // Bouncing box: left edge
    while (strobes < 304) do_strobe();
    probe("x304.in",  0, mby, 31, 63, 31);
    probe("x304.out", 32, mby, 0, 0, 16);
    do_strobe();
    probe("x305.out", 3, mby, 0, 0, 16);
    probe("x305.in",  4, mby, 31, 63, 31);

    // Reserved mode is black
    mode = 3'd6;
    do_strobe();
    probe("rsvd", 100, 70, 0, 0, 0);

    // Reset in the middle of a frame clears mode and box
    mode    = 3'd3;
    sx      = 10'd100;
    sy      = 10'd70;
    de_i    = 1'b1;
    vs_i    = 1'b0;
    RESET_n = 1'b0;
    tick();
    check("mrst.red",   32'(vid.RED),   0);
    check("mrst.de",    32'(vid.DE),    0);
    check("mrst.vsync", 32'(vid.VSYNC), 1);
    RESET_n = 1'b1;
    tick();
    check("mrst.sq.red",   32'(vid.RED),   11);
    check("mrst.sq.green", 32'(vid.GREEN), 6);
    mbx  = 0;
    mby  = 0;
    mdxn = 1'b0;
    mdyn = 1'b0;
    do_strobe();
    probe("mrst.box.in",   4, 4, 31, 63, 31);
    probe("mrst.box.left", 3, 4, 0, 0, 16);
    probe("mrst.box.top",  4, 3, 0, 0, 16);

    // One FRAME pulse per strobe, never on the following cycle
    check("frame.pulses", 32'(frame_seen), 32'(strobes));
    check("frame.extra",  32'(frame_extra), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pattern_gen.md
Name: pattern_gen

Overview:
- Parametrised successor to the single-pattern 480p colour-square generator.
- Sits between the video timing generator (simple_480p) and the registered DVI/Pmod RGB pins, in the PCLK domain.
- Generates one of several selectable test patterns at configurable channel widths and resolution, including an animated bouncing box.
- Delays sync and DE so all outputs stay cycle-aligned, and changes mode only on frame boundaries.

Parameters:
- CORDW, 10, screen coordinate width in bits
- H_RES, 640, active pixels per line
- V_RES, 480, active lines per frame
- R_W, 5, red channel width
- G_W, 6, green channel width
- B_W, 5, blue channel width
- CHK_LOG2, 5, checker square size is 2^CHK_LOG2 pixels
- BOX, 32, bouncing-box edge length in pixels
- STEP, 4, box displacement per frame in pixels
- SYNC_IDLE, 1, inactive level of HSYNC/VSYNC (1 = active-low syncs)

Ports:
- PCLK  in  1  pixel clock
- RESET_n  in  1  synchronous active-low reset, sampled on PCLK rising edge
- MODE  in  3  requested pattern; applied at next frame strobe
- SX  in  CORDW  current x from timing generator
- SY  in  CORDW  current y from timing generator
- DE_I  in  1  data enable from timing generator
- HSYNC_I  in  1  hsync from timing generator
- VSYNC_I  in  1  vsync from timing generator
- DE  out  1  DE_I delayed 1 cycle
- HSYNC  out  1  HSYNC_I delayed 1 cycle
- VSYNC  out  1  VSYNC_I delayed 1 cycle
- RED  out  R_W  registered red
- GREEN  out  G_W  registered green
- BLUE  out  B_W  registered blue
- FRAME  out  1  one-cycle pulse, registered, coincident with frame strobe + 1

Behaviour:
- Reset (RESET_n low at a PCLK edge):
  - RED/GREEN/BLUE=0, DE=0, HSYNC=VSYNC=SYNC_IDLE, FRAME=0.
  - Active mode=0, bx=by=0, dx=dy=+1.
  - Reset mid-frame takes effect on the next edge; there is no partial state.
- Latency: exactly 1 PCLK from SX/SY/DE_I/syncs to RGB/DE/syncs. All outputs are registered.
- Frame strobe: internal, combinational; true when SX==0 and SY==V_RES (first pixel of vertical blanking).
  - On strobe: active mode <= MODE; box position updates; FRAME pulses on the following cycle.
  - MODE changes between strobes are ignored.
- Blanking: DE_I=0 forces the next RGB to 0 regardless of mode.
- Width rule: patterns are defined at 5/6/5 or at full-scale.
  - 5/6/5 values are MSB-aligned to R_W/G_W/B_W: zero-pad LSBs if wider, drop LSBs if narrower.
  - Full-scale means all ones.
- Mode 0, colour square (sx<256 && sy<256, else black):
  - r = sy[7:6]*8 + sx[7:5]
  - g = sy[5:0]
  - b = sx[4:0]
- Mode 1, eight vertical bars, each H_RES/8 wide (integer), index = sx/(H_RES/8), clamped to 7:
  - Order: white, yellow, cyan, green, magenta, red, blue, black.
  - Components are full-scale or 0.
- Mode 2, checkerboard: white when SX[CHK_LOG2]^SY[CHK_LOG2]=1, else black.
- Mode 3, bouncing box:
  - White inside bx<=sx<bx+BOX and by<=sy<by+BOX.
  - Elsewhere background: blue at MSB-only (1000..b), red=green=0.
- Modes 4-7: solid black (reserved).
- Box update on strobe, per axis (x shown; y identical with V_RES, by, dy):
  - dx=+1 and bx+BOX+STEP>H_RES: dx<=-1, bx<=bx-STEP.
  - dx=+1 otherwise: bx<=bx+STEP.
  - dx=-1 and bx<STEP: dx<=+1, bx<=bx+STEP.
  - dx=-1 otherwise: bx<=bx-STEP.
- Box position updates every frame regardless of active mode.

Test Plan:
- Reset held 3 cycles with DE_I=1, HSYNC_I=0 -> RGB=0, DE=0, HSYNC=VSYNC=1, FRAME=0. After release, mode 0 is active.
- Mode 0, SX=100, SY=70, DE_I=1 -> one cycle later RED=11, GREEN=6, BLUE=4. Then DE_I=0 -> RGB=0 next cycle.
- Mode 1 via strobe:
  - SX=85 -> RED=31, GREEN=63, BLUE=0.
  - SX=639 -> RGB=0.
  - Rerun with R_W=G_W=B_W=8: SX=85 -> 255/255/0.
- Mode deferral: MODE=2 driven mid-frame at SY=100 -> pattern remains mode 0 until the strobe. At SX=32, SY=0 of the next frame, output is white.
- Bounce x: 152 strobes -> bx=608. Next strobe -> bx=604, dx=-1. In mode 3, SX=604, SY=by -> white; SX=603 -> blue MSB.
- Bounce y: 112 strobes -> by=448. Next strobe -> by=444. Left/top edge: from bx=0 with dx=-1 -> bx=4, dx=+1. FRAME pulses once per strobe.
